l1_writeback_buffer: RTL and testbench
======================================

Name: l1_writeback_buffer

Overview:
- Drains dirty victim lines out of the 4-way L1 D-cache data array and streams them to the memory/bus side.
- Owns the data array's read port while capturing: drives set/way, takes read data one cycle later, and stores address plus line in a small FIFO.
- Sends each line to the bus as BUS_BYTES-wide beats using a valid/ready handshake.
- Sits between the cache controller's eviction path and the downstream write channel.

Parameters:
- SETS, 128, number of sets in the data array
- WAYS, 4, associativity
- LINE_BYTES, 64, bytes per cache line
- BUS_BYTES, 16, bytes per bus beat; LINE_BYTES must be an integer multiple of BUS_BYTES
- DEPTH, 2, number of buffered lines (>=1)
- ADDR_WIDTH, 32, byte address width

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- evict_valid  in  1  eviction request valid
- evict_ready  out  1  request accepted when valid&&ready
- evict_set  in  $clog2(SETS)  victim set index
- evict_way  in  $clog2(WAYS)  victim way
- evict_addr  in  ADDR_WIDTH  victim line byte address; low $clog2(LINE_BYTES) bits are ignored and forced to 0
- da_rd_req  out  1  request for the data array read port
- da_rd_gnt  in  1  read port granted this cycle
- da_read_set  out  $clog2(SETS)  set driven to the data array
- da_read_way  out  $clog2(WAYS)  way driven to the data array
- da_read_data  in  LINE_BYTES*8  data array read data, valid the cycle after grant
- wb_valid  out  1  beat valid
- wb_ready  in  1  downstream accepts beat
- wb_addr  out  ADDR_WIDTH  line address of the current line
- wb_data  out  BUS_BYTES*8  beat data
- wb_last  out  1  final beat of the line
- wb_idle  out  1  FIFO empty and capture FSM in IDLE
- snoop_addr  in  ADDR_WIDTH  snoop line address
- snoop_hit  out  1  snoop matches a buffered line
- snoop_data  out  LINE_BYTES*8  line data of the matching entry

Behaviour:
- Reset (async assert, sync release):
  - FSM returns to IDLE; FIFO is emptied and the beat counter cleared.
  - All outputs are 0 except wb_idle=1.
  - Any in-flight line is discarded.
- Capture FSM:
  - IDLE: evict_ready = (count<DEPTH). On handshake, latch set, way and line address, then go to REQ.
  - REQ: da_rd_req=1, da_read_set/da_read_way driven from the latched values. On da_rd_gnt go to CAP; otherwise hold.
  - CAP: latch da_read_data together with the address into the FIFO tail (push), then go to IDLE.
  - evict_ready is 0 in REQ and CAP.
  - da_read_set/da_read_way hold their last value when not requesting.
- Latency:
  - Request accepted at cycle T, grant at T+1, data captured at the T+2 edge.
  - If the FIFO was empty, wb_valid=1 at T+3.
  - Back-to-back evictions are accepted no faster than one every 3 cycles.
- Drain:
  - wb_valid=1 whenever the FIFO is non-empty.
  - Beat k (0..LINE_BYTES/BUS_BYTES-1) carries line bytes [k*BUS_BYTES +: BUS_BYTES], lowest bytes first.
  - wb_addr is the head line address, constant for all beats of that line.
  - wb_last=1 on the final beat.
  - The beat counter advances only on wb_valid&&wb_ready.
  - The head entry is popped on the handshake of its last beat, and the counter wraps to 0.
  - While wb_valid=1, wb_data, wb_addr and wb_last stay stable until accepted.
- FIFO:
  - Push and pop in the same cycle leaves count unchanged.
  - Full: evict_ready=0.
  - Empty: wb_valid=0.
  - Order is strictly FIFO.
- wb_idle = (count==0)&&(state==IDLE). Used by the fence/flush logic.
- evict_valid is ignored while evict_ready=0; the requester must hold it.
- A single-beat line (LINE_BYTES==BUS_BYTES) asserts wb_last on every beat.

Optional Feature:
- Macro: L1_WB_SNOOP_FWD_EN.
- Defined: snoop_hit is combinational. It is 1 if snoop_addr's line address equals the address of any valid FIFO entry or of the entry currently in REQ/CAP.
  - snoop_data returns the matching FIFO entry's data.
  - If several entries match, the youngest wins.
  - If the only match is the capture entry, snoop_hit=1 and snoop_data=0; the controller must retry.
- Undefined: snoop_hit=0 and snoop_data=0 constantly, and snoop_addr is unused.

Decomposition:
- Package cache_pkg holds:
  - LINE_BYTES, BUS_BYTES and derived BEATS_PER_LINE / OFFSET_BITS.
  - typedef line_t (LINE_BYTES*8 bits).
  - typedef wb_entry_t struct {addr, data}.
  - enum wb_cap_state_t {IDLE, REQ, CAP}.
- One sub-module, wb_entry_fifo: synchronous FIFO of wb_entry_t with push, pop, count, and a flat read view of all entries for the snoop compare.

Test Plan:
- Single eviction: set=5, way=2, addr=0x1000, grant immediate, line bytes i=i → wb_valid at T+3; 4 beats, beat0 data 0x0F0E..00, wb_last on beat3, wb_addr=0x1000 for all beats.
- Grant stall: da_rd_gnt held low 5 cycles → da_rd_req stays 1 and set/way stay stable; data captured the cycle after grant.
- Full/backpressure: wb_ready=0, issue 3 evictions (DEPTH=2) → third evict_ready stays 0 until wb_ready rises and the first line's last beat is accepted; lines leave in FIFO order.
- Simultaneous push/pop: a capture completes in the same cycle as a last-beat handshake → count unchanged; the next line follows without a gap.
- Reset mid-drain: assert rst_n=0 after beat1 → wb_valid=0 at once, wb_idle=1, and no stale beats appear after release.
- With L1_WB_SNOOP_FWD_EN: buffered addr=0x2040 and snoop_addr=0x2065 → snoop_hit=1 and snoop_data equals that line. Without the macro, snoop_hit=0.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared line geometry, writeback entry type and capture FSM states
package cache_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int BUS_BYTES      = 16;
  localparam int ADDR_WIDTH     = 32;
  localparam int BEATS_PER_LINE = LINE_BYTES / BUS_BYTES;
  localparam int OFFSET_BITS    = $clog2(LINE_BYTES);

  typedef logic [LINE_BYTES*8-1:0] line_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    line_t                 data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2
  } wb_cap_state_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// rtl/wb_entry_fifo.sv - synchronous FIFO of writeback entries with an age-ordered view
module wb_entry_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output wb_entry_t        head,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  // Storage needs no reset: nothing downstream looks at an entry beyond count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

  // Index 0 is the oldest entry, DEPTH-1 the youngest slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]     = mem[PW'((int'(rd_ptr) + i) % DEPTH)];
      entry_valid[i] = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/l1_writeback_buffer.sv
// rtl/l1_writeback_buffer.sv - L1 victim writeback buffer; snoop forwarding under L1_WB_SNOOP_FWD_EN
module l1_writeback_buffer
  import cache_pkg::*;
#(
  parameter int SETS       = 128,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = cache_pkg::LINE_BYTES,
  parameter int BUS_BYTES  = cache_pkg::BUS_BYTES,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     evict_valid,
  output logic                     evict_ready,
  input  logic [$clog2(SETS)-1:0]  evict_set,
  input  logic [$clog2(WAYS)-1:0]  evict_way,
  input  logic [ADDR_WIDTH-1:0]    evict_addr,
  output logic                     da_rd_req,
  input  logic                     da_rd_gnt,
  output logic [$clog2(SETS)-1:0]  da_read_set,
  output logic [$clog2(WAYS)-1:0]  da_read_way,
  input  logic [LINE_BYTES*8-1:0]  da_read_data,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [ADDR_WIDTH-1:0]    wb_addr,
  output logic [BUS_BYTES*8-1:0]   wb_data,
  output logic                     wb_last,
  output logic                     wb_idle,
  input  logic [ADDR_WIDTH-1:0]    snoop_addr,
  output logic                     snoop_hit,
  output logic [LINE_BYTES*8-1:0]  snoop_data
);

  localparam int OB    = $clog2(LINE_BYTES);
  localparam int BEATS = LINE_BYTES / BUS_BYTES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BUS_W = BUS_BYTES * 8;

  wb_cap_state_t         state;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [BW-1:0]         beat;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  ready_next;
  wb_entry_t             head;
  wb_entry_t             view [DEPTH];
  logic [DEPTH-1:0]      view_valid;

  assign accept = evict_valid && evict_ready;
  assign push   = (state == CAP);
  assign pop    = wb_valid && wb_ready && wb_last;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  // evict_ready is registered, so it is precomputed from next state and next occupancy.
  assign ready_next = ((state == CAP) || ((state == IDLE) && !accept)) &&
                      (count_next < CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap_addr    <= '0;
      da_rd_req   <= 1'b0;
      da_read_set <= '0;
      da_read_way <= '0;
      evict_ready <= 1'b0;
    end else begin
      evict_ready <= ready_next;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_addr    <= {evict_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
            da_read_set <= evict_set;
            da_read_way <= evict_way;
            da_rd_req   <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (da_rd_gnt) begin
            da_rd_req <= 1'b0;
            state     <= CAP;
          end
        end
        CAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  wb_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  ('{addr: cap_addr, data: da_read_data}),
    .pop         (pop),
    .count       (count),
    .head        (head),
    .entries     (view),
    .entry_valid (view_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beat <= '0;
    else if (wb_valid && wb_ready)
      beat <= wb_last ? '0 : beat + 1'b1;
  end

  // Gating on wb_valid keeps the beat outputs at zero whenever the FIFO is empty.
  assign wb_valid = (count != '0);
  assign wb_addr  = wb_valid ? head.addr : '0;
  assign wb_data  = wb_valid ? head.data[int'(beat)*BUS_W +: BUS_W] : '0;
  assign wb_last  = wb_valid && (beat == BW'(BEATS - 1));
  assign wb_idle  = (count == '0) && (state == IDLE);

`ifdef L1_WB_SNOOP_FWD_EN
  logic [ADDR_WIDTH-1:0] snoop_line;
  logic                  unused_offsets;

  assign snoop_line     = {snoop_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
  assign unused_offsets = ^{evict_addr[OB-1:0], snoop_addr[OB-1:0]};

  // Capture entry has no data yet: it reports a hit with zero data so the caller retries.
  always_comb begin
    snoop_hit  = (state != IDLE) && (cap_addr == snoop_line);
    snoop_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (view_valid[i] && (view[i].addr == snoop_line)) begin
        snoop_hit  = 1'b1;
        snoop_data = view[i].data;
      end
    end
  end
`else
  logic unused_snoop;

  assign snoop_hit  = 1'b0;
  assign snoop_data = '0;

  always_comb begin
    unused_snoop = ^{snoop_addr, view_valid, evict_addr[OB-1:0]};
    for (int i = 0; i < DEPTH; i++)
      unused_snoop = unused_snoop ^ (^view[i]);
  end
`endif

endmodule

// File: tb/tb_l1_writeback_buffer.sv
// tb/tb_l1_writeback_buffer.sv - directed bench for l1_writeback_buffer
module tb_l1_writeback_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         evict_valid, evict_ready;
  logic [6:0]   evict_set;
  logic [1:0]   evict_way;
  logic [31:0]  evict_addr;
  logic         da_rd_req, da_rd_gnt;
  logic [6:0]   da_read_set;
  logic [1:0]   da_read_way;
  logic [511:0] da_read_data;
  logic         wb_valid, wb_ready, wb_last, wb_idle;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic [31:0]  snoop_addr;
  logic         snoop_hit;
  logic [511:0] snoop_data;

  always #5 clk = ~clk;

  l1_writeback_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_set(evict_set), .evict_way(evict_way), .evict_addr(evict_addr),
    .da_rd_req(da_rd_req), .da_rd_gnt(da_rd_gnt),
    .da_read_set(da_read_set), .da_read_way(da_read_way), .da_read_data(da_read_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_last(wb_last), .wb_idle(wb_idle),
    .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Array contents: byte i of (set, way) is set*4 + way + 234 + i, so set 5 way 2 gives byte i = i.
  function automatic logic [511:0] pattern(input logic [6:0] s, input logic [1:0] w);
    logic [511:0] p;
    for (int i = 0; i < 64; i++)
      p[i*8 +: 8] = 8'(int'(s) * 4 + int'(w) + 234 + i);
    return p;
  endfunction

  int gnt_delay = 0;
  int req_cycles;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      req_cycles <= 0;
    else if (da_rd_req && !da_rd_gnt)
      req_cycles <= req_cycles + 1;
    else
      req_cycles <= 0;
  end

  assign da_rd_gnt = da_rd_req && (req_cycles >= gnt_delay);

  always @(posedge clk)
    da_read_data <= (da_rd_req && da_rd_gnt) ? pattern(da_read_set, da_read_way) : {64{8'hA5}};

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   mon_beat = 0;
  int   lines_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mon_beat <= 0;
    end else begin
      if (evict_valid && evict_ready)
        exp_q.push_back('{addr: {evict_addr[31:6], 6'b0}, data: pattern(evict_set, evict_way)});
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          check_bit("unexpected_beat", 1'b1, 1'b0);
        end else begin
          check_val("beat_addr", 512'(wb_addr), 512'(exp_q[0].addr));
          check_val("beat_data", 512'(wb_data), 512'(exp_q[0].data[mon_beat*128 +: 128]));
          check_bit("beat_last", wb_last, mon_beat == 3);
          if (mon_beat == 3) begin
            void'(exp_q.pop_front());
            mon_beat   <= 0;
            lines_done <= lines_done + 1;
          end else begin
            mon_beat <= mon_beat + 1;
          end
        end
      end
    end
  end

  task automatic evict(input logic [6:0] s, input logic [1:0] w, input logic [31:0] a);
    int n;
    n = 0;
    evict_set = s; evict_way = w; evict_addr = a; evict_valid = 1'b1;
    while (!evict_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_bit("evict_accepted", evict_ready, 1'b1);
    @(posedge clk); #1;
    evict_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!wb_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_bit("wb_valid_seen", wb_valid, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(wb_idle && exp_q.size() == 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_bit("drain_idle", wb_idle, 1'b1);
  endtask

  typedef struct {
    logic [6:0]   set;
    logic [1:0]   way;
    logic [31:0]  addr;
    int           gnt_delay;
    logic [31:0]  exp_addr;
    logic [127:0] exp_beat0;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    logic stale;

    vecs[0] = '{7'd5,   2'd2, 32'h0000_1000, 0, 32'h0000_1000, 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[1] = '{7'd0,   2'd0, 32'h0000_0ABC, 0, 32'h0000_0A80, 128'hF9F8F7F6F5F4F3F2F1F0EFEEEDECEBEA};
    vecs[2] = '{7'd127, 2'd3, 32'hFFFF_FFFF, 2, 32'hFFFF_FFC0, 128'hF8F7F6F5F4F3F2F1F0EFEEEDECEBEAE9};
    vecs[3] = '{7'd6,   2'd1, 32'h1234_5678, 1, 32'h1234_5640, 128'h1211100F0E0D0C0B0A09080706050403};

    evict_valid = 1'b0; evict_set = '0; evict_way = '0; evict_addr = '0;
    wb_ready = 1'b0; snoop_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_wb_valid", wb_valid, 1'b0);
    check_bit("rst_wb_idle", wb_idle, 1'b1);
    check_bit("rst_evict_ready", evict_ready, 1'b0);
    check_bit("rst_rd_req", da_rd_req, 1'b0);
    check_bit("rst_wb_last", wb_last, 1'b0);
    check_bit("rst_snoop_hit", snoop_hit, 1'b0);
    check_val("rst_wb_data", 512'(wb_data), 512'(0));
    check_val("rst_wb_addr", 512'(wb_addr), 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_bit("post_rst_ready", evict_ready, 1'b1);

    // Single eviction with cycle-exact latency
    evict_set = 7'd5; evict_way = 2'd2; evict_addr = 32'h1000; evict_valid = 1'b1;
    check_bit("t0_ready", evict_ready, 1'b1);
    @(posedge clk); #1;
    evict_valid = 1'b0;
    check_bit("t1_rd_req", da_rd_req, 1'b1);
    check_val("t1_set", 512'(da_read_set), 512'(5));
    check_val("t1_way", 512'(da_read_way), 512'(2));
    check_bit("t1_ready", evict_ready, 1'b0);
    @(posedge clk); #1;
    check_bit("t2_rd_req", da_rd_req, 1'b0);
    check_bit("t2_valid", wb_valid, 1'b0);
    check_bit("t2_ready", evict_ready, 1'b0);
    @(posedge clk); #1;
    check_bit("t3_valid", wb_valid, 1'b1);
    check_val("t3_addr", 512'(wb_addr), 512'(32'h1000));
    check_val("t3_beat0", 512'(wb_data), 512'(128'h0F0E0D0C0B0A09080706050403020100));
    check_bit("t3_last", wb_last, 1'b0);
    check_bit("t3_ready", evict_ready, 1'b1);
    check_bit("t3_idle", wb_idle, 1'b0);
    @(posedge clk); #1;
    check_val("stall_beat0_stable", 512'(wb_data), 512'(128'h0F0E0D0C0B0A09080706050403020100));
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_bit("seq_last", wb_last, k == 3);
      check_val("seq_addr", 512'(wb_addr), 512'(32'h1000));
      @(posedge clk); #1;
    end
    check_bit("t_end_valid", wb_valid, 1'b0);
    check_bit("t_end_idle", wb_idle, 1'b1);
    wb_ready = 1'b0;

    // Table-driven single evictions
    for (int i = 0; i < 4; i++) begin
      gnt_delay = vecs[i].gnt_delay;
      evict(vecs[i].set, vecs[i].way, vecs[i].addr);
      wait_valid();
      check_val("vec_addr", 512'(wb_addr), 512'(vecs[i].exp_addr));
      check_val("vec_beat0", 512'(wb_data), 512'(vecs[i].exp_beat0));
      check_bit("vec_last0", wb_last, 1'b0);
      wb_ready = 1'b1;
      wait_idle();
      wb_ready = 1'b0;
    end

    // Grant stall: five cycles without grant
    gnt_delay = 5;
    wb_ready = 1'b1;
    evict(7'd9, 2'd1, 32'h2345);
    for (int k = 0; k < 5; k++) begin
      check_bit("stall_req", da_rd_req, 1'b1);
      check_bit("stall_gnt", da_rd_gnt, 1'b0);
      check_val("stall_set", 512'(da_read_set), 512'(9));
      check_val("stall_way", 512'(da_read_way), 512'(1));
      @(posedge clk); #1;
    end
    check_bit("stall_gnt_now", da_rd_gnt, 1'b1);
    @(posedge clk); #1;
    check_bit("stall_cap_req", da_rd_req, 1'b0);
    check_val("stall_set_held", 512'(da_read_set), 512'(9));
    check_bit("stall_cap_valid", wb_valid, 1'b0);
    @(posedge clk); #1;
    check_bit("stall_valid", wb_valid, 1'b1);
    wait_idle();

    // Full FIFO with backpressure
    gnt_delay = 0;
    wb_ready = 1'b0;
    base = lines_done;
    evict(7'd1, 2'd0, 32'h3000);
    evict(7'd2, 2'd1, 32'h3040);
    evict_set = 7'd3; evict_way = 2'd3; evict_addr = 32'h30C0; evict_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_bit("full_ready_low", evict_ready, 1'b0);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    n = 0;
    while (!evict_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_bit("full_ready_rises", evict_ready, 1'b1);
    check_val("full_first_popped", 512'(lines_done - base), 512'(1));
    @(posedge clk); #1;
    evict_valid = 1'b0;
    wait_idle();
    check_val("full_lines_out", 512'(lines_done - base), 512'(3));

    // Capture completes on the same edge as a last-beat handshake
    evict(7'd4, 2'd0, 32'h4000);
    wait_valid();
    @(posedge clk); #1;
    evict_set = 7'd4; evict_way = 2'd1; evict_addr = 32'h4400; evict_valid = 1'b1;
    check_bit("pp_ready", evict_ready, 1'b1);
    @(posedge clk); #1;
    evict_valid = 1'b0;
    check_bit("pp_req", da_rd_req, 1'b1);
    @(posedge clk); #1;
    check_bit("pp_last", wb_last, 1'b1);
    check_val("pp_addr_a", 512'(wb_addr), 512'(32'h4000));
    @(posedge clk); #1;
    check_bit("pp_no_gap", wb_valid, 1'b1);
    check_val("pp_addr_b", 512'(wb_addr), 512'(32'h4400));
    check_bit("pp_last_b", wb_last, 1'b0);
    check_bit("pp_count_kept", evict_ready, 1'b1);
    wait_idle();

    // Snoop against capture entry and buffered line
    wb_ready = 1'b0;
    gnt_delay = 3;
    evict(7'd3, 2'd0, 32'h2040);
    snoop_addr = 32'h2065;
    #1;
`ifdef L1_WB_SNOOP_FWD_EN
    check_bit("snoop_cap_hit", snoop_hit, 1'b1);
`else
    check_bit("snoop_cap_hit", snoop_hit, 1'b0);
`endif
    check_val("snoop_cap_data", snoop_data, 512'(0));
    wait_valid();
    #1;
`ifdef L1_WB_SNOOP_FWD_EN
    check_bit("snoop_buf_hit", snoop_hit, 1'b1);
    check_val("snoop_buf_data", snoop_data, pattern(7'd3, 2'd0));
`else
    check_bit("snoop_buf_hit", snoop_hit, 1'b0);
    check_val("snoop_buf_data", snoop_data, 512'(0));
`endif
    snoop_addr = 32'h2080;
    #1;
    check_bit("snoop_miss", snoop_hit, 1'b0);
    wb_ready = 1'b1;
    wait_idle();
    snoop_addr = 32'h2065;
    #1;
    check_bit("snoop_empty", snoop_hit, 1'b0);

    // Reset in the middle of a drain
    gnt_delay = 0;
    evict(7'd8, 2'd2, 32'h5000);
    wait_valid();
    @(posedge clk); #1;
    check_bit("mid_beat1_valid", wb_valid, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_valid", wb_valid, 1'b0);
    check_bit("mid_rst_idle", wb_idle, 1'b1);
    check_bit("mid_rst_ready", evict_ready, 1'b0);
    check_bit("mid_rst_last", wb_last, 1'b0);
    check_val("mid_rst_data", 512'(wb_data), 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (wb_valid) stale = 1'b1;
    end
    check_bit("no_stale_beats", stale, 1'b0);
    check_bit("post_mid_idle", wb_idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
